apb_cmd_master: RTL and testbench
=================================

# apb_cmd_master

Single-outstanding APB initiator driving the timer's 12-bit APB slave port (`tim_psel`/`tim_penable`/…). A simple valid/ready command port feeds it, and a held response port returns read data and error status. It sits in the test harness and the SoC bridge path: `cmd_*` comes from a host sequencer, and the `p*` outputs connect one-to-one to the timer's `tim_p*` inputs. It performs standard two-phase SETUP/ACCESS transfers, supports PSTRB, and has an optional wait-state watchdog.

## Interface
- `TIMEOUT_CYCLES`, default 16: number of ACCESS cycles without `pready` before abort. Range 2..255. Used only with the watchdog.
- `clk` in 1: single clock; all logic rising-edge.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when high with `cmd_valid`.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 12: byte address.
- `cmd_wdata` in 32: write data.
- `cmd_strb` in 4: byte strobes. Forced to 0 on reads.
- `rsp_valid` out 1: response held.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: captured `prdata`. 0 for writes.
- `rsp_err` out 1: `pslverr`, or timeout.
- `rsp_timeout` out 1: abort caused by the watchdog.
- `psel`, `penable`, `pwrite` out 1 each: APB control.
- `paddr` out 12, `pwdata` out 32, `pstrb` out 4: APB payload.
- `pready` in 1, `pslverr` in 1, `prdata` in 32: APB completion.

## Operation
- FSM states and transitions:
  - IDLE: `cmd_ready` = 1. When `cmd_valid` is high, register `cmd_write`, `cmd_addr`, `cmd_wdata` and `cmd_strb` (strb masked to 0 if read), then go to SETUP.
  - SETUP: `psel` = 1, `penable` = 0. Always go to ACCESS next.
  - ACCESS: `psel` = 1, `penable` = 1.
    - If `pready` = 1: capture `prdata` (reads only; writes load 0) and `pslverr`, then go to RESP.
    - Otherwise stay in ACCESS.
  - RESP: `rsp_valid` = 1, `psel` = 0, `penable` = 0. When `rsp_ready` is high, go to IDLE.
- `cmd_ready` is high only in IDLE. No command is accepted while a response is pending, so there is exactly one outstanding transaction.
- `paddr`, `pwrite`, `pwdata` and `pstrb` come from registers. They are stable from SETUP through the last ACCESS cycle and keep their value in RESP and IDLE; they change only on command accept.
- `pslverr` and `prdata` are sampled only in the ACCESS cycle where `pready` = 1. They are ignored at all other times.
- `rsp_rdata`, `rsp_err` and `rsp_timeout` are stable while `rsp_valid` is high.
- Reset value of every output is 0, except `cmd_ready` = 1. State resets to IDLE and the wait counter resets to 0.
- Reset asserted mid-transfer drops `psel`/`penable` immediately (asynchronously) and discards the response.

## Timing
- Command accepted at edge 0. SETUP is cycle 1, ACCESS starts at cycle 2.
- Zero-wait slave (`pready` high in the first ACCESS cycle): `rsp_valid` rises in cycle 3.
- Each wait state adds one cycle.
- If `rsp_ready` is held high: IDLE is in cycle 4, so the next command is accepted at cycle 4. Minimum is 4 cycles per transfer.
- `rsp_ready` high while `rsp_valid` is low has no effect.
- `cmd_valid` high in RESP is ignored until IDLE.
- A transfer whose `pslverr` = 1 completes normally with `rsp_err` = 1, `rsp_timeout` = 0, and `rsp_rdata` = `prdata` for reads.

## Configuration
- `APB_CMD_MASTER_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entering ACCESS and increments each ACCESS cycle in which `pready` = 0.
  - When the count reaches `TIMEOUT_CYCLES - 1` and `pready` is still 0, the FSM goes to RESP with `rsp_err` = 1, `rsp_timeout` = 1, `rsp_rdata` = 0.
  - `psel`/`penable` deassert in the next cycle.
  - If `pready` = 1 arrives in the same cycle as expiry, it wins: a normal completion, no timeout.
- Not defined:
  - No counter logic is synthesised, and `rsp_timeout` is tied to 0.
  - ACCESS waits indefinitely for `pready`.

## Test plan
- **Reset values:** assert `rst_n` = 0 mid-ACCESS. `psel`, `penable` and `rsp_valid` go to 0 asynchronously, and `cmd_ready` = 1 after release.
- **Zero-wait write:** `cmd_write` = 1, `addr` = 0x004, `wdata` = 0xDEADBEEF, `strb` = 0xF, slave returns `pready` in its first cycle. Required:
  - SETUP in cycle 1, ACCESS in cycle 2.
  - `paddr` = 0x004 and `pstrb` = 0xF stable across both cycles.
  - `rsp_valid` in cycle 3 with `rsp_err` = 0 and `rsp_rdata` = 0.
- **Read with 3 wait states:** `addr` = 0x010, slave drives `prdata` = 0x12345678 on `pready`. Required:
  - ACCESS lasts 4 cycles.
  - `rsp_rdata` = 0x12345678.
  - `pstrb` = 0 throughout.
- **Slave error and back-pressure:** slave read returns `pslverr` = 1 with `prdata` = 0xA5A5A5A5, and `rsp_ready` is held low for 5 cycles. Required:
  - `rsp_valid`, `rsp_err` = 1 and `rsp_rdata` = 0xA5A5A5A5 held stable for 5 cycles.
  - `cmd_ready` = 0 for those 5 cycles, while `cmd_valid` is held high.
  - The second command starts only after the handshake.
- **Timeout** (macro on, `TIMEOUT_CYCLES` = 4): `pready` stuck at 0. Required:
  - Exactly 4 ACCESS cycles.
  - RESP with `rsp_err` = 1 and `rsp_timeout` = 1.
  - Repeat with `pready` = 1 on the 4th ACCESS cycle: normal completion with `rsp_timeout` = 0.
- **Back-to-back:** `cmd_valid` and `rsp_ready` held high, 8 writes to 0x000..0x01C. Required:
  - One transfer every 4 cycles.
  - `paddr` increments by 4 per transfer.

Source files
------------

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding APB initiator for the timer's 12-bit slave.
// A valid/ready command port starts one SETUP/ACCESS transfer at a time, and
// the result is held on the response port until it is consumed.
// Optional feature macro: APB_CMD_MASTER_TIMEOUT_EN enables the ACCESS
// wait-state watchdog (TIMEOUT_CYCLES ACCESS cycles without pready).
// With the macro undefined, ACCESS waits for pready indefinitely and
// rsp_timeout is tied to 0.

module apb_cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // APB initiator
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  input  logic        pready,
  input  logic        pslverr,
  input  logic [31:0] prdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        w_accept;
  logic        w_complete;
  logic        w_expire;

  // Control outputs are registered from the next state so they never glitch
  logic        r_cmd_ready;
  logic        r_psel;
  logic        r_penable;
  logic        r_rsp_valid;

  // APB payload, loaded only on command accept
  logic        r_pwrite;
  logic [11:0] r_paddr;
  logic [31:0] r_pwdata;
  logic [3:0]  r_pstrb;

  // Response payload, loaded only when a transfer ends
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid;
  assign w_complete = (r_state == ST_ACCESS) && pready;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam logic [7:0] LP_WAIT_LIMIT = 8'(TIMEOUT_CYCLES - 32'd1);

  logic [7:0] r_wait_cnt;
  logic       r_rsp_timeout;

  // Expiry only when pready is still low; a late pready in the same cycle wins
  assign w_expire = (r_state == ST_ACCESS) && !pready && (r_wait_cnt == LP_WAIT_LIMIT);

  // Wait counter: cleared in SETUP (i.e. on entry to ACCESS), counts ACCESS cycles without pready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= 8'd0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= 8'd0;
    end else if ((r_state == ST_ACCESS) && !pready) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end

  // Timeout flag travels with the rest of the response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_expire) begin
      r_rsp_timeout <= 1'b1;
    end else begin
      r_rsp_timeout <= r_rsp_timeout;
    end
  end

  assign rsp_timeout = r_rsp_timeout;
`else
  assign w_expire    = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // Next-state logic for the SETUP/ACCESS/RESP sequence
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          w_state_nxt = ST_RESP;
        end else if (w_expire) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register plus control outputs decoded from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable   <= (w_state_nxt == ST_ACCESS);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
    end
  end

  // APB payload capture on command accept; strobes are meaningless for reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwrite <= 1'b0;
      r_paddr  <= 12'd0;
      r_pwdata <= 32'd0;
      r_pstrb  <= 4'd0;
    end else if (w_accept) begin
      r_pwrite <= cmd_write;
      r_paddr  <= cmd_addr;
      r_pwdata <= cmd_wdata;
      r_pstrb  <= cmd_write ? cmd_strb : 4'd0;
    end else begin
      r_pwrite <= r_pwrite;
      r_paddr  <= r_paddr;
      r_pwdata <= r_pwdata;
      r_pstrb  <= r_pstrb;
    end
  end

  // Response capture: prdata/pslverr are only trusted in the pready cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else if (w_complete) begin
      r_rsp_rdata <= r_pwrite ? 32'd0 : prdata;
      r_rsp_err   <= pslverr;
    end else if (w_expire) begin
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b1;
    end else begin
      r_rsp_rdata <= r_rsp_rdata;
      r_rsp_err   <= r_rsp_err;
    end
  end

  assign cmd_ready = r_cmd_ready;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign rsp_valid = r_rsp_valid;
  assign pwrite    = r_pwrite;
  assign paddr     = r_paddr;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

  apb_cmd_master_chk #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_ready   (r_cmd_ready),
    .psel        (r_psel),
    .penable     (r_penable),
    .rsp_valid   (r_rsp_valid),
    .pwrite      (r_pwrite),
    .paddr       (r_paddr),
    .pwdata      (r_pwdata),
    .pstrb       (r_pstrb),
    .rsp_rdata   (r_rsp_rdata),
    .rsp_err     (r_rsp_err),
    .rsp_timeout (rsp_timeout)
  );

endmodule

// Protocol invariants of the initiator, kept out of the datapath module.
module apb_cmd_master_chk #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic        clk,
  input logic        rst_n,
  input logic        cmd_ready,
  input logic        psel,
  input logic        penable,
  input logic        rsp_valid,
  input logic        pwrite,
  input logic [11:0] paddr,
  input logic [31:0] pwdata,
  input logic [3:0]  pstrb,
  input logic [31:0] rsp_rdata,
  input logic        rsp_err,
  input logic        rsp_timeout
);

  // Watchdog limit must fit the 8-bit wait counter and allow at least one wait state
  a_param_range: assert property (@(posedge clk)
    (TIMEOUT_CYCLES >= 32'd2) && (TIMEOUT_CYCLES <= 32'd255));

  // penable is only ever asserted inside a selected transfer
  a_penable_psel: assert property (@(posedge clk) disable iff (!rst_n)
    penable |-> psel);

  // Exactly one phase at a time: accepting, transferring, or holding a response
  a_phase_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot({cmd_ready, psel, rsp_valid}));

  // Payload does not move while the slave can see it
  a_payload_stable: assert property (@(posedge clk) disable iff (!rst_n)
    psel |=> (!psel || $stable({pwrite, paddr, pwdata, pstrb})));

  // Held response does not move until it is consumed
  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    rsp_valid |=> (!rsp_valid || $stable({rsp_rdata, rsp_err, rsp_timeout})));

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master. The bench plays host and APB slave.
// Expected results come from a transaction-level model: a transfer lasts
// 1 SETUP + (waits+1) ACCESS cycles (capped by the watchdog when the
// APB_CMD_MASTER_TIMEOUT_EN build is used), and returns prdata/pslverr
// from the pready cycle, or 0 data for writes.

module tb_apb_cmd_master;

  localparam int unsigned TO = 4;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = 12'd0;
  logic [31:0] cmd_wdata = 32'd0;
  logic [3:0]  cmd_strb = 4'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = 32'd0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_cmd_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transfer, slave asserting pready after 'waits' wait states,
  // response held for 'hold' cycles before rsp_ready.
  task automatic xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                      input logic [3:0] st, input int waits, input logic [31:0] rd,
                      input logic err, input int hold, input logic keep_valid);
    logic [3:0]  exp_strb;
    logic [31:0] exp_rd;
    logic        exp_err;
    bit          timed_out;
    int          exp_acc;
    int          acc;
    exp_strb  = wr ? st : 4'h0;
    timed_out = TO_EN && (waits >= int'(TO));
    exp_acc   = timed_out ? int'(TO) : waits + 1;
    exp_rd    = timed_out ? 32'd0 : (wr ? 32'd0 : rd);
    exp_err   = timed_out ? 1'b1 : err;

    chk("idle_cmd_ready", cmd_ready, 32'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_strb = st;
    tick();
    // scramble the command bus: the APB payload must not follow it
    cmd_valid = keep_valid; cmd_addr = 12'($urandom); cmd_wdata = $urandom; cmd_strb = 4'($urandom);
    chk("setup_psel", psel, 32'd1);
    chk("setup_penable", penable, 32'd0);
    chk("setup_cmd_ready", cmd_ready, 32'd0);
    chk("setup_paddr", paddr, 32'(addr));
    chk("setup_pwrite", pwrite, 32'(wr));
    chk("setup_pwdata", pwdata, wd);
    chk("setup_pstrb", pstrb, 32'(exp_strb));
    tick();
    acc = 0;
    while (psel === 1'b1 && penable === 1'b1 && acc < 300) begin
      chk("access_paddr", paddr, 32'(addr));
      chk("access_pstrb", pstrb, 32'(exp_strb));
      chk("access_pwdata", pwdata, wd);
      pready  = (acc == waits);
      prdata  = (acc == waits) ? rd : $urandom;
      pslverr = (acc == waits) ? err : 1'($urandom);
      tick();
      acc++;
    end
    pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
    chk("access_cycles", 32'(acc), 32'(exp_acc));
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid", rsp_valid, 32'd1);
      chk("rsp_psel", psel, 32'd0);
      chk("rsp_penable", penable, 32'd0);
      chk("rsp_cmd_ready", cmd_ready, 32'd0);
      chk("rsp_rdata", rsp_rdata, exp_rd);
      chk("rsp_err", rsp_err, 32'(exp_err));
      chk("rsp_timeout", rsp_timeout, 32'(timed_out));
      chk("rsp_paddr_held", paddr, 32'(addr));
      rsp_ready = (h == hold);
      tick();
    end
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 32'd0);
    chk("post_cmd_ready", cmd_ready, 32'd1);
    chk("post_psel", psel, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit reached before summary");
    $fatal(1, "time limit");
  end

  initial begin
    int k;
    int nsetup;
    int last;
    int cyc;
    bit acc_now;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 32'd1);
    chk("rst_psel", psel, 32'd0);
    chk("rst_penable", penable, 32'd0);
    chk("rst_rsp_valid", rsp_valid, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", rsp_err, 32'd0);
    chk("rst_rsp_timeout", rsp_timeout, 32'd0);
    chk("rst_pwrite", pwrite, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    chk("rst_pstrb", pstrb, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // zero-wait write
    xfer(1'b1, 12'h004, 32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0, 0, 1'b0);
    // read with 3 wait states
    xfer(1'b0, 12'h010, 32'h0BADF00D, 4'hF, 3, 32'h12345678, 1'b0, 0, 1'b0);
    // slave error with 5 cycles of back-pressure, next command already waiting
    xfer(1'b0, 12'h020, 32'h0, 4'h3, 1, 32'hA5A5A5A5, 1'b1, 5, 1'b1);
    xfer(1'b1, 12'h024, 32'hCAFE0001, 4'h5, 0, 32'h0, 1'b0, 0, 1'b0);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    // watchdog expiry with pready stuck low, then pready on the last allowed cycle
    xfer(1'b0, 12'h030, 32'h0, 4'h0, 1000, 32'h11111111, 1'b0, 1, 1'b0);
    xfer(1'b0, 12'h034, 32'h0, 4'h0, int'(TO) - 1, 32'h22222222, 1'b0, 0, 1'b0);
`endif

    // randomized transfers against the transaction model
    for (int i = 0; i < 16; i++) begin
      xfer(1'($urandom), 12'($urandom), $urandom, 4'($urandom),
           int'($urandom_range(0, 4)), $urandom, 1'($urandom),
           int'($urandom_range(0, 3)), 1'b0);
    end

    // back-to-back writes 0x000..0x01C with cmd_valid and rsp_ready held high
    pready = 1'b1; pslverr = 1'b0; rsp_ready = 1'b1;
    cmd_write = 1'b1; cmd_strb = 4'hF; cmd_addr = 12'h000; cmd_wdata = $urandom;
    cmd_valid = 1'b1;
    k = 0; nsetup = 0; last = -1; cyc = 0;
    while (nsetup < 8 && cyc < 100) begin
      if (psel === 1'b1 && penable === 1'b0) begin
        chk("b2b_paddr", paddr, 32'(nsetup * 4));
        if (nsetup > 0) chk("b2b_period", 32'(cyc - last), 32'd4);
        last = cyc;
        nsetup++;
      end
      acc_now = (cmd_ready === 1'b1) && (cmd_valid === 1'b1);
      tick();
      cyc++;
      if (acc_now) begin
        k++;
        cmd_addr = 12'(k * 4);
        cmd_wdata = $urandom;
        if (k == 8) cmd_valid = 1'b0;
      end
    end
    chk("b2b_count", 32'(nsetup), 32'd8);
    cyc = 0;
    while (!(cmd_ready === 1'b1 && psel === 1'b0) && cyc < 20) begin
      tick();
      cyc++;
    end
    pready = 1'b0; rsp_ready = 1'b0;
    chk("b2b_drain_idle", cmd_ready, 32'd1);
    repeat (3) tick();
    chk("b2b_no_extra_psel", psel, 32'd0);

    // reset asserted mid-ACCESS
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 12'h0AC; cmd_strb = 4'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    chk("pre_rst_access", {30'd0, psel, penable}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_psel", psel, 32'd0);
    chk("async_rst_penable", penable, 32'd0);
    chk("async_rst_rsp_valid", rsp_valid, 32'd0);
    chk("async_rst_cmd_ready", cmd_ready, 32'd1);
    @(negedge clk);
    pready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_cmd_ready", cmd_ready, 32'd1);
    tick();
    chk("post_rst_rsp_discarded", rsp_valid, 32'd0);
    chk("post_rst_psel", psel, 32'd0);
    pready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
